// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell plus a carry flop, LSB first,
// with a start/busy/done handshake and registered sum/cout/ovf results.
`timescale 1ns/1ps
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             s_bit;
   logic             carry_next;
   logic [WIDTH-1:0] b_eff;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      res_d      = res_q;
      cnt_d      = cnt_q;
      carry_d    = carry_q;
      a_msb_d    = a_msb_q;
      b_msb_d    = b_msb_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
      ovf_d      = ovf_q;
      b_eff      = sub ? ~b : b;
      s_bit      = opa_q[0] ^ opb_q[0] ^ carry_q;
      carry_next = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               opa_d   = a;
               opb_d   = b_eff;
               carry_d = sub;
               cnt_d   = '0;
               res_d   = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b_eff[WIDTH-1];
            end
         end
         RUN: begin
            opa_d   = {1'b0, opa_q[WIDTH-1:1]};
            opb_d   = {1'b0, opb_q[WIDTH-1:1]};
            carry_d = carry_next;
            res_d   = (WIDTH-1)'({s_bit, res_q} >> 1);
            // The final bit goes straight to the result registers.
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               sum_d   = {s_bit, res_q};
               cout_d  = carry_next;
               ovf_d   = (a_msb_q == b_msb_q) && (s_bit != a_msb_q);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 arithmetic, handshake, reset and
// ignored-start cases, plus a WIDTH=16 instance with start held high.
`timescale 1ns/1ps
module tb_serial_adder;

   logic        clk;
   logic        rst;
   logic        start, sub;
   logic [7:0]  a, b;
   logic        busy, done, cout, ovf;
   logic [7:0]  sum;

   logic        start16, sub16;
   logic [15:0] a16, b16;
   logic        busy16, done16, cout16, ovf16;
   logic [15:0] sum16;

   int total = 0;
   int bad   = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic sb, input logic [7:0] av, input logic [7:0] bv);
      start = st;
      sub   = sb;
      a     = av;
      b     = bv;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Full operation: start, WIDTH busy cycles, one done pulse, results held afterwards.
   task automatic runOp(input string tag, input logic sb, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec, input logic eo);
      applyStimulus(1'b1, sb, av, bv);
      tick();
      applyStimulus(1'b0, ~sb, ~av, ~bv);
      for (int i = 0; i < 8; i++) begin
         checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
         checkOutput({tag, "_early_done"}, 32'(done), 32'd0);
         tick();
      end
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
      checkOutput({tag, "_sum"}, 32'(sum), 32'(es));
      checkOutput({tag, "_cout"}, 32'(cout), 32'(ec));
      checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eo));
      tick();
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_sum_hold"}, 32'(sum), 32'(es));
   endtask

   initial begin
      int n;
      int dn;
      rst     = 1'b1;
      start16 = 1'b0;
      sub16   = 1'b0;
      a16     = 16'h0000;
      b16     = 16'h0000;
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_sum", 32'(sum), 32'd0);
      checkOutput("rst_cout", 32'(cout), 32'd0);
      checkOutput("rst_ovf", 32'(ovf), 32'd0);
      checkOutput("rst_busy16", 32'(busy16), 32'd0);
      checkOutput("rst_sum16", 32'(sum16), 32'd0);

      runOp("add_2d_1c", 1'b0, 8'h2D, 8'h1C, 8'h49, 1'b0, 1'b0);
      runOp("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      runOp("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
      runOp("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
      runOp("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

      // Second start on the 3rd busy cycle must be dropped.
      applyStimulus(1'b1, 1'b0, 8'h2D, 8'h1C);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      tick();
      applyStimulus(1'b1, 1'b1, 8'h55, 8'h33);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("ign_done", 32'(done), 32'd1);
      checkOutput("ign_sum", 32'(sum), 32'h49);
      checkOutput("ign_cout", 32'(cout), 32'd0);
      dn = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (done || busy) dn++;
      end
      checkOutput("ign_no_second_op", 32'(dn), 32'd0);

      // Reset on the 4th busy cycle discards the partial result.
      applyStimulus(1'b1, 1'b0, 8'h11, 8'h22);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      tick();
      tick();
      checkOutput("mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_done", 32'(done), 32'd0);
      checkOutput("mid_rst_sum", 32'(sum), 32'd0);
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dn++;
      end
      checkOutput("mid_rst_no_done", 32'(dn), 32'd0);
      runOp("after_rst", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

      // WIDTH=16 with start held high: one op per 18 cycles.
      sub16   = 1'b0;
      a16     = 16'hFFFF;
      b16     = 16'h0001;
      start16 = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!done16 && n <= 40);
      checkOutput("w16_latency", 32'(n), 32'd17);
      checkOutput("w16_sum", 32'(sum16), 32'h0000);
      checkOutput("w16_cout", 32'(cout16), 32'd1);
      checkOutput("w16_ovf", 32'(ovf16), 32'd0);
      checkOutput("w16_busy_off", 32'(busy16), 32'd0);
      for (int p = 0; p < 2; p++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!done16 && n <= 40);
         checkOutput("w16_period", 32'(n), 32'd18);
         checkOutput("w16_sum_rep", 32'(sum16), 32'h0000);
         checkOutput("w16_cout_rep", 32'(cout16), 32'd1);
      end
      start16 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
